// File: rtl/resp_framer_if.sv
// Bundle of dispatcher handshake, uart_tx and sample-memory read signals for resp_framer.
// The master side is the framer; the slave side is the surrounding system.
interface resp_framer_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  activate;
    logic                  done;
    logic [7:0]            cmd;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [7:0]            length;

    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_active;
    logic                  tx_done;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_oe;
    logic [7:0]            mem_data;

    modport master (
        input  activate, cmd, start_addr, length,
        input  tx_active, tx_done, mem_data,
        output done, tx_data, tx_start, mem_addr, mem_oe
    );

    modport slave (
        output activate, cmd, start_addr, length,
        output tx_active, tx_done, mem_data,
        input  done, tx_data, tx_start, mem_addr, mem_oe
    );
endinterface

// File: rtl/resp_framer.sv
// Sends a response frame (SYNC, cmd, len, payload..., XOR checksum) over uart_tx,
// reading the payload from sample memory while the dispatcher holds activate.
module resp_framer #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input logic          clk_50mhz,
    input logic          reset,
    resp_framer_if.master bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LATCH     = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] NEXT      = 3'd4;
    localparam logic [2:0] FETCH     = 3'd5;
    localparam logic [2:0] CAPTURE   = 3'd6;
    localparam logic [2:0] FINISH    = 3'd7;

    localparam logic [2:0] F_SYNC    = 3'd0;
    localparam logic [2:0] F_CMD     = 3'd1;
    localparam logic [2:0] F_LEN     = 3'd2;
    localparam logic [2:0] F_PAYLOAD = 3'd3;
    localparam logic [2:0] F_CSUM    = 3'd4;

    logic [2:0]            state;
    logic [2:0]            field;
    logic [7:0]            cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            idx;
    logic [7:0]            tx_byte;
    logic [7:0]            csum;

    logic                  done_r;
    logic                  tx_start_r;
    logic [7:0]            tx_data_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  mem_oe_r;

    assign bus.done     = done_r;
    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_oe   = mem_oe_r;

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            field      <= F_SYNC;
            cmd_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            idx        <= '0;
            tx_byte    <= '0;
            csum       <= '0;
            done_r     <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            mem_addr_r <= '0;
            mem_oe_r   <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state)
                IDLE: begin
                    done_r   <= 1'b0;
                    mem_oe_r <= 1'b0;
                    if (bus.activate)
                        state <= LATCH;
                end
                LATCH: begin
                    cmd_q   <= bus.cmd;
                    addr_q  <= bus.start_addr;
                    len_q   <= bus.length;
                    csum    <= '0;
                    idx     <= '0;
                    tx_byte <= SYNC_BYTE;
                    field   <= F_SYNC;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (!bus.tx_active) begin
                        tx_data_r  <= tx_byte;
                        tx_start_r <= 1'b1;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_done)
                        state <= NEXT;
                end
                NEXT: begin
                    // Abort is only taken here, so a byte already handed to uart_tx always completes.
                    if (!bus.activate) begin
                        state <= IDLE;
                    end else begin
                        case (field)
                            F_SYNC: begin
                                tx_byte <= cmd_q;
                                csum    <= csum ^ cmd_q;
                                field   <= F_CMD;
                                state   <= ISSUE;
                            end
                            F_CMD: begin
                                tx_byte <= len_q;
                                csum    <= csum ^ len_q;
                                field   <= F_LEN;
                                state   <= ISSUE;
                            end
                            F_LEN, F_PAYLOAD: begin
                                if (idx < len_q) begin
                                    state <= FETCH;
                                end else begin
                                    tx_byte <= csum;
                                    field   <= F_CSUM;
                                    state   <= ISSUE;
                                end
                            end
                            default: state <= FINISH;
                        endcase
                    end
                end
                FETCH: begin
                    mem_addr_r <= addr_q + ADDR_WIDTH'(idx);
                    mem_oe_r   <= 1'b1;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    tx_byte  <= bus.mem_data;
                    csum     <= csum ^ bus.mem_data;
                    idx      <= idx + 8'd1;
                    mem_oe_r <= 1'b0;
                    field    <= F_PAYLOAD;
                    state    <= ISSUE;
                end
                FINISH: begin
                    if (bus.activate) begin
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_resp_framer.sv
// Directed scoreboard bench for resp_framer: expected frame bytes and memory
// addresses are queued when a job starts and popped as the DUT emits them.
module tb_resp_framer;
    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    resp_framer_if #(.ADDR_WIDTH(8)) bus ();

    resp_framer #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk_50mhz (clk),
        .reset     (rst_n),
        .bus       (bus.master)
    );

    logic [7:0] mem [256];
    logic       uart_busy = 1'b0;
    logic       hold_busy = 1'b0;
    assign bus.mem_data  = mem[bus.mem_addr];
    assign bus.tx_active = uart_busy | hold_busy;

    int compared   = 0;
    int mismatched = 0;
    int starts     = 0;
    int oe_cycles  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] addr_exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // uart_tx model: busy for a few cycles after each start, then a one-cycle done pulse
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                uart_busy = 1'b1;
                repeat (3) @(negedge clk);
                uart_busy   = 1'b0;
                bus.tx_done = 1'b1;
                @(negedge clk);
                bus.tx_done = 1'b0;
            end
        end
    end

    // output monitor / scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                starts++;
                check("tx_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tx_byte", bus.tx_data, e);
                end
            end
            if (bus.mem_oe === 1'b1) begin
                oe_cycles++;
                check("addr_pending", addr_exp_q.size() > 0, 1);
                if (addr_exp_q.size() > 0) begin
                    e = addr_exp_q.pop_front();
                    check("mem_addr", bus.mem_addr, e);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic start_job(input logic [7:0] c, input logic [7:0] a, input logic [7:0] l);
        logic [7:0] cs;
        logic [7:0] ad;
        cs = c ^ l;
        exp_q.push_back(8'hA5);
        exp_q.push_back(c);
        exp_q.push_back(l);
        for (int i = 0; i < int'(l); i++) begin
            ad = a + 8'(i);
            exp_q.push_back(mem[ad]);
            addr_exp_q.push_back(ad);
            cs = cs ^ mem[ad];
        end
        exp_q.push_back(cs);
        starts         = 0;
        oe_cycles      = 0;
        bus.cmd        = c;
        bus.start_addr = a;
        bus.length     = l;
        bus.activate   = 1'b1;
    endtask

    task automatic finish_job(input int nbytes, input int noe);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", bus.done, 1);
        check("start_count", starts, nbytes);
        check("oe_cycles", oe_cycles, noe);
        check("bytes_left", exp_q.size(), 0);
        check("addrs_left", addr_exp_q.size(), 0);
        bus.activate = 1'b0;
        @(negedge clk);
        check("done_release", bus.done, 0);
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"},     bus.done, 0);
        check({tag, "_tx_start"}, bus.tx_start, 0);
        check({tag, "_tx_data"},  bus.tx_data, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_oe"},   bus.mem_oe, 0);
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        bus.activate   = 1'b0;
        bus.cmd        = '0;
        bus.start_addr = '0;
        bus.length     = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h10] = 8'h10; mem[8'h11] = 8'h20; mem[8'h12] = 8'h30;
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03; mem[8'h01] = 8'h04;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // basic 3-byte frame, including first-start latency
        start_job(8'h22, 8'h10, 8'd3);
        @(negedge clk);
        check("latency_c1", bus.tx_start, 0);
        @(negedge clk);
        check("latency_c2", bus.tx_start, 0);
        @(negedge clk);
        check("latency_c3", bus.tx_start, 1);
        finish_job(7, 3);

        // zero-length frame: header and checksum only
        start_job(8'h72, 8'h00, 8'd0);
        finish_job(4, 0);

        // address wrap across 0xFF -> 0x00
        start_job(8'h5A, 8'hFE, 8'd4);
        finish_job(8, 4);

        // transmitter busy before the first byte
        hold_busy = 1'b1;
        start_job(8'h3C, 8'h20, 8'd2);
        repeat (50) @(negedge clk);
        check("busy_hold_no_start", starts, 0);
        hold_busy = 1'b0;
        finish_job(6, 2);

        // abort during the second payload byte
        start_job(8'h11, 8'h40, 8'd5);
        n = 0;
        while (starts < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        bus.activate = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_starts", starts, 5);
        check("abort_done", bus.done, 0);
        check("abort_bytes_left", exp_q.size(), 4);
        check("abort_oe_cycles", oe_cycles, 2);
        exp_q.delete();
        addr_exp_q.delete();

        // job after abort proves the FSM returned to idle
        start_job(8'h0F, 8'h80, 8'd1);
        finish_job(5, 1);

        // asynchronous reset while the CMD byte is in flight
        start_job(8'h22, 8'h10, 8'd3);
        n = 0;
        while (starts < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_tx_data", bus.tx_data, 8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        bus.activate = 1'b0;
        exp_q.delete();
        addr_exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        start_job(8'h22, 8'h10, 8'd3);
        finish_job(7, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
